ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 138 +++++++++++++
 tb/tb_ahb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant among four masters with a parking master,
// locked-sequence support and a hold limit that ends long unlocked tenures.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [1:0]             hmaster,
  output logic                   hmastlock,
  output logic [1:0]             arb_state
);

  localparam int                     CW         = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0]          HOLD_LAST  = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0]          HOLD_FIRE  = CW'(MAX_HOLD - 2);
  localparam logic [1:0]             DEF_IDX    = 2'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT  = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [1:0]             HTRANS_SEQ = 2'b11;

  typedef enum logic [1:0] {
    S_PARK   = 2'd0,
    S_GRANT  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  // Returns {found, index}; the search starts just after 'last' and wraps.
  function automatic logic [2:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                         input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [1:0] encode(input logic [NUM_MASTERS-1:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (g[i]) r = 2'(i);
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [1:0]             last_q, last_d, owner;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             pick_all, pick_others;
  logic                   release_bus;

  assign owner       = encode(hgrant);
  assign pick_all    = rr_pick(hbusreq, last_q);
  assign pick_others = rr_pick(hbusreq & ~hgrant, last_q);
  assign arb_state   = state_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = hgrant;
    last_d      = last_q;
    cnt_d       = cnt_q;
    release_bus = 1'b0;
    case (state_q)
      S_PARK: begin
        grant_d = DEF_GRANT;
        if (pick_all[2]) begin
          state_d = S_GRANT;
          grant_d = NUM_MASTERS'(1) << pick_all[1:0];
          last_d  = pick_all[1:0];
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (!hbusreq[owner]) begin
          release_bus = 1'b1;
        end else if (hlock[owner]) begin
          state_d = S_LOCKED;
        end else if (cnt_q >= HOLD_FIRE && pick_others[2] && htrans != HTRANS_SEQ) begin
          // Hold limit reached: hand over, never in the middle of a burst.
          grant_d = NUM_MASTERS'(1) << pick_others[1:0];
          last_d  = pick_others[1:0];
          cnt_d   = '0;
        end else if (cnt_q < HOLD_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOCKED: begin
        if (!hlock[owner]) begin
          if (!hbusreq[owner]) release_bus = 1'b1;
          else                 state_d     = S_GRANT;
        end
      end
      default: state_d = S_PARK;
    endcase

    if (release_bus) begin
      cnt_d = '0;
      if (pick_all[2]) begin
        state_d = S_GRANT;
        grant_d = NUM_MASTERS'(1) << pick_all[1:0];
        last_d  = pick_all[1:0];
      end else begin
        state_d = S_PARK;
        grant_d = DEF_GRANT;
      end
    end
  end

  // Nothing moves unless the current transfer completes (hready high).
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= S_PARK;
      hgrant    <= DEF_GRANT;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 2'd3;
    end else if (hready) begin
      state_q   <= state_d;
      hgrant    <= grant_d;
      hmaster   <= owner;
      hmastlock <= hlock[owner];
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: vector table, directed multi-cycle
// sequences and a randomized run against a rule-level reference model.
module tb_ahb_arbiter;

  localparam int MAX_HOLD = 16;
  localparam int DEF_M    = 0;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;
  logic [1:0] arb_state;

  int total = 0;
  int bad   = 0;

  ahb_arbiter #(
    .NUM_MASTERS(4),
    .MAX_HOLD(MAX_HOLD),
    .DEFAULT_MASTER(DEF_M)
  ) dut (
    .hclk(hclk),
    .hreset(hreset),
    .hbusreq(hbusreq),
    .hlock(hlock),
    .htrans(htrans),
    .hready(hready),
    .hgrant(hgrant),
    .hmaster(hmaster),
    .hmastlock(hmastlock),
    .arb_state(arb_state)
  );

  // ---------------- clock ----------------
  always #5 hclk = ~hclk;

  // ---------------- driver / checker ----------------
  task automatic tick(input bit rst, input logic [3:0] req, input logic [3:0] lock,
                      input logic [1:0] tr, input bit rdy);
    hreset  = rst;
    hbusreq = req;
    hlock   = lock;
    htrans  = tr;
    hready  = rdy;
    @(posedge hclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] m,
                           input logic ml);
    check({name, ".hgrant"}, 32'(hgrant), 32'(g));
    check({name, ".hmaster"}, 32'(hmaster), 32'(m));
    check({name, ".hmastlock"}, 32'(hmastlock), 32'(ml));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] tr;
    bit         rdy;
    logic [3:0] g;
    logic [1:0] m;
    logic       ml;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit rst, input logic [3:0] req, input logic [3:0] lock,
                     input logic [1:0] tr, input bit rdy, input logic [3:0] g,
                     input logic [1:0] m, input logic ml);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.tr = tr; v.rdy = rdy;
    v.g = g; v.m = m; v.ml = ml;
    vq.push_back(v);
  endtask

  // ---------------- reference model ----------------
  int m_owner, m_last, m_held, m_master;
  bit m_parked, m_locked, m_mastlock;

  function automatic int rr_model(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input bit rst, input logic [3:0] req, input logic [3:0] lock,
                            input logic [1:0] tr, input bit rdy);
    int w, prev, nxt;
    bit rel;
    logic [3:0] others;
    if (rst) begin
      m_parked = 1; m_locked = 0; m_owner = DEF_M; m_held = 0;
      m_last = 3; m_master = DEF_M; m_mastlock = 0;
      return;
    end
    if (!rdy) return;
    prev = m_owner;
    rel  = 0;
    if (m_parked) begin
      w = rr_model(req, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_parked = 0; m_held = 0;
      end
    end else if (m_locked) begin
      if (!lock[m_owner]) begin
        m_locked = 0;
        rel = !req[m_owner];
      end
    end else if (!req[m_owner]) begin
      rel = 1;
    end else if (lock[m_owner]) begin
      m_locked = 1;
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      nxt = m_held + 1;
      if (nxt >= MAX_HOLD - 1 && others != 0 && tr != 2'b11) begin
        w = rr_model(others, m_last);
        m_owner = w; m_last = w; m_held = 0;
      end else begin
        m_held = (nxt > MAX_HOLD - 1) ? MAX_HOLD - 1 : nxt;
      end
    end
    if (rel) begin
      w = rr_model(req, m_last);
      m_held = 0;
      if (w < 0) begin
        m_parked = 1; m_owner = DEF_M;
      end else begin
        m_owner = w; m_last = w;
      end
    end
    m_master   = prev;
    m_mastlock = lock[prev];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] req_r, lock_r;
    logic [1:0] tr_r;
    bit rst_r, rdy_r;

    hreset = 1'b1; hbusreq = '0; hlock = '0; htrans = '0; hready = 1'b1;

    // Table: idle parking, full round robin, stalled handover, lock/unlock, reset.
    add(1, 4'b0000, 4'b0000, 2'b00, 1, 4'b0001, 2'd0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 4'b0000, 2'b00, 1, 4'b0001, 2'd0, 0);
    add(0, 4'b1111, 4'b0000, 2'b10, 1, 4'b0001, 2'd0, 0);
    add(0, 4'b1110, 4'b0000, 2'b10, 1, 4'b0010, 2'd0, 0);
    add(0, 4'b1101, 4'b0000, 2'b10, 1, 4'b0100, 2'd1, 0);
    add(0, 4'b1011, 4'b0000, 2'b10, 1, 4'b1000, 2'd2, 0);
    add(0, 4'b0111, 4'b0000, 2'b10, 1, 4'b0001, 2'd3, 0);
    add(0, 4'b0000, 4'b0000, 2'b00, 1, 4'b0001, 2'd0, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b0010, 4'b0000, 2'b10, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b0010, 4'b0000, 2'b10, 1, 4'b0010, 2'd0, 0);
    add(0, 4'b0010, 4'b0000, 2'b10, 1, 4'b0010, 2'd1, 0);
    add(0, 4'b0010, 4'b0010, 2'b10, 1, 4'b0010, 2'd1, 1);
    add(0, 4'b0010, 4'b0010, 2'b11, 1, 4'b0010, 2'd1, 1);
    add(0, 4'b0000, 4'b0000, 2'b00, 1, 4'b0001, 2'd1, 0);
    add(0, 4'b0000, 4'b0000, 2'b00, 1, 4'b0001, 2'd0, 0);
    add(1, 4'b1000, 4'b0000, 2'b10, 0, 4'b0001, 2'd0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].rst, vq[i].req, vq[i].lock, vq[i].tr, vq[i].rdy);
      check_out($sformatf("vec%0d", i), vq[i].g, vq[i].m, vq[i].ml);
    end

    // Locked owner ignores a competing request until it unlocks.
    tick(1, 4'b0000, 4'b0000, 2'b00, 1);
    tick(0, 4'b0100, 4'b0100, 2'b10, 1);
    check_out("lock_grant", 4'b0100, 2'd0, 0);
    tick(0, 4'b0100, 4'b0100, 2'b11, 1);
    check_out("lock_enter", 4'b0100, 2'd2, 1);
    for (int i = 0; i < 40; i++) begin
      tick(0, 4'b0110, 4'b0100, 2'($urandom_range(0, 3)), 1);
      check_out("lock_hold", 4'b0100, 2'd2, 1);
    end
    tick(0, 4'b0010, 4'b0000, 2'b00, 1);
    check_out("lock_release", 4'b0010, 2'd2, 0);

    // Hold limit: forced handover on the 15th hready edge after the grant.
    tick(1, 4'b0000, 4'b0000, 2'b00, 1);
    tick(0, 4'b1001, 4'b0000, 2'b10, 1);
    check("hold_grant", 32'(hgrant), 32'h1);
    for (int k = 1; k <= 14; k++) begin
      tick(0, 4'b1001, 4'b0000, 2'b10, 1);
      check("hold_keep", 32'(hgrant), 32'h1);
    end
    tick(0, 4'b1001, 4'b0000, 2'b10, 1);
    check("hold_force", 32'(hgrant), 32'h8);

    // Same, but SEQ at the limit defers the handover to the first non-SEQ edge.
    tick(1, 4'b0000, 4'b0000, 2'b00, 1);
    tick(0, 4'b1001, 4'b0000, 2'b10, 1);
    for (int k = 1; k <= 14; k++) tick(0, 4'b1001, 4'b0000, 2'b10, 1);
    check("defer_pre", 32'(hgrant), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick(0, 4'b1001, 4'b0000, 2'b11, 1);
      check("defer_seq", 32'(hgrant), 32'h1);
    end
    tick(0, 4'b1001, 4'b0000, 2'b10, 1);
    check("defer_done", 32'(hgrant), 32'h8);

    // Handover pending while hready is low for 10 cycles.
    tick(1, 4'b0000, 4'b0000, 2'b00, 1);
    tick(0, 4'b0100, 4'b0000, 2'b10, 1);
    check_out("stall_grant", 4'b0100, 2'd0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 4'b0010, 4'b0000, 2'b10, 0);
      check_out("stall_hold", 4'b0100, 2'd0, 0);
    end
    tick(0, 4'b0010, 4'b0000, 2'b10, 1);
    check_out("stall_done", 4'b0010, 2'd2, 0);
    tick(0, 4'b0010, 4'b0000, 2'b10, 1);
    check_out("stall_lag", 4'b0010, 2'd1, 0);

    // Reset while master 3 holds a locked sequence and hready is low.
    tick(1, 4'b0000, 4'b0000, 2'b00, 1);
    tick(0, 4'b1000, 4'b1000, 2'b10, 1);
    tick(0, 4'b1000, 4'b1000, 2'b11, 1);
    check_out("rst_locked", 4'b1000, 2'd3, 1);
    tick(1, 4'b1000, 4'b1000, 2'b11, 0);
    check_out("rst_override", 4'b0001, 2'd0, 0);

    // Randomized run against the reference model.
    req_r = '0; lock_r = '0;
    model_step(1, '0, '0, '0, 1);
    tick(1, '0, '0, '0, 1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) req_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) lock_r = 4'($urandom_range(0, 15));
      tr_r  = 2'($urandom_range(0, 3));
      rdy_r = ($urandom_range(0, 3) != 0);
      rst_r = ($urandom_range(0, 299) == 0);
      model_step(rst_r, req_r, lock_r & req_r, tr_r, rdy_r);
      tick(rst_r, req_r, lock_r & req_r, tr_r, rdy_r);
      check("rand.hgrant", 32'(hgrant), 32'(4'b0001 << m_owner));
      check("rand.hmaster", 32'(hmaster), 32'(m_master));
      check("rand.hmastlock", 32'(hmastlock), 32'(m_mastlock));
      check("rand.onehot", 32'($onehot(hgrant)), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
